// File: rtl/nasti_burst_master_if.sv
// NASTI (AXI4) channel bundle: AW, W, B, AR, R with full ready/valid handshakes.
// Latency: none, wires only.
// Backpressure: every channel is independently stalled by its own ready signal.
//
// Modports:
//   master - drives AW/W/AR payload+valid and B/R ready.
//   slave  - drives AW/W/AR ready and B/R payload+valid.
interface nasti_channel #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    // write address
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    // write data
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;
    // write response
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;
    // read address
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    // read data
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_burst_master.sv
// Single-outstanding NASTI initiator: one command becomes one INCR burst (AW+W+B or AR+R).
// Latency: AW/AR valid the cycle after command accept; done pulses the cycle after the final B/R handshake.
// Backpressure: W and R data pass straight through, so wd/rd stall exactly as the bus does; req_ready only in IDLE.
//
// Ports: clk/rst (sync, active-high); req_* command; wd_* write-data stream in;
//        rd_* read-data stream out; done/err completion pulse; nasti master port.
module nasti_burst_master #(
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  DATA_WIDTH = 128,
    parameter int                  ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0] ID         = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic                    err,
    nasti_channel.master            nasti
);
    localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic                    err_flag_q;
    logic                    done_q;
    logic                    err_q;

    logic                    last_beat;
    logic                    w_hs;
    logic                    r_hs;
    logic                    r_beat_err;
    logic                    r_term;

    always_comb begin
        state_nxt  = state;
        last_beat  = (cnt_q == len_q);
        w_hs       = 1'b0;
        r_hs       = 1'b0;
        r_beat_err = 1'b0;
        r_term     = 1'b0;
        case (state)
            IDLE: if (req_valid && req_ready) state_nxt = req_write ? AW : AR;
            AW:   if (nasti.aw_ready) state_nxt = W;
            W: begin
                w_hs = wd_valid && nasti.w_ready;
                if (w_hs && last_beat) state_nxt = B;
            end
            B:    if (nasti.b_valid) state_nxt = IDLE;
            AR:   if (nasti.ar_ready) state_nxt = R;
            R: begin
                r_hs       = nasti.r_valid && rd_ready;
                // r_last disagreeing with our own beat count covers both early
                // and missing r_last.
                r_beat_err = nasti.r_resp[1] | (nasti.r_last != last_beat);
                r_term     = r_hs && (last_beat || nasti.r_last);
                if (r_term) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q     <= req_addr;
                        len_q      <= req_len;
                        cnt_q      <= '0;
                        err_flag_q <= 1'b0;
                    end
                end
                W: if (w_hs) cnt_q <= cnt_q + 8'd1;
                B: begin
                    if (nasti.b_valid) begin
                        done_q <= 1'b1;
                        err_q  <= nasti.b_resp[1] | err_flag_q;
                    end
                end
                R: begin
                    if (r_hs) begin
                        cnt_q      <= cnt_q + 8'd1;
                        err_flag_q <= err_flag_q | r_beat_err;
                        if (r_term) begin
                            done_q <= 1'b1;
                            err_q  <= err_flag_q | r_beat_err;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold off the next command during the done cycle so the caller sees
    // completion before it can issue again.
    assign req_ready = (state == IDLE) && !done_q;
    assign done      = done_q;
    assign err       = err_q;

    assign wd_ready  = (state == W) && nasti.w_ready;
    assign rd_valid  = (state == R) && nasti.r_valid;
    assign rd_data   = nasti.r_data;
    assign rd_last   = (state == R) && last_beat;

    assign nasti.aw_id     = ID;
    assign nasti.aw_addr   = addr_q;
    assign nasti.aw_len    = len_q;
    assign nasti.aw_size   = SIZE;
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_user   = '0;
    assign nasti.aw_valid  = (state == AW);

    assign nasti.w_data    = wd_data;
    assign nasti.w_strb    = wd_strb;
    assign nasti.w_last    = (state == W) && last_beat;
    assign nasti.w_user    = '0;
    assign nasti.w_valid   = (state == W) && wd_valid;

    assign nasti.b_ready   = (state == B);

    assign nasti.ar_id     = ID;
    assign nasti.ar_addr   = addr_q;
    assign nasti.ar_len    = len_q;
    assign nasti.ar_size   = SIZE;
    assign nasti.ar_burst  = 2'b01;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = '0;
    assign nasti.ar_valid  = (state == AR);

    assign nasti.r_ready   = (state == R) && rd_ready;

    // IDs are fixed and only one transaction is in flight, so response IDs,
    // user bits and the OKAY/EXOKAY distinction carry no information here.
    logic unused_sig;
    assign unused_sig = ^{nasti.b_id, nasti.b_user, nasti.b_resp[0],
                          nasti.r_id, nasti.r_user, nasti.r_resp[0]};
endmodule

// File: tb/tb_nasti_burst_master.sv
// Directed bench for nasti_burst_master: table of burst transactions against a
// scripted slave, plus hand-written reset and back-to-back sequences.
module tb_nasti_burst_master;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic [SW-1:0] wd_strb;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last, done, err;

    always #5 clk = ~clk;

    nasti_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1)) nasti ();

    nasti_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1), .ID(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .nasti(nasti)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  len;
        int          addr_delay;  // cycles AW/AR valid is held before ready
        bit          bresp_err;   // write: respond SLVERR
        int          err_beat;    // read: beat index answered with DECERR (-1 none)
        int          last_beat;   // read: beat carrying r_last (-1 = len, 300 = never)
        bit          stall;       // random valids, toggling readies
        int          exp_beats;
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] pat(input logic [15:0] seed, input int beat);
        logic [31:0] b;
        b = 32'(beat);
        return {seed, 16'h0, b, 32'h0, 32'hDEADBEEF + b};
    endfunction

    task automatic slave_idle();
        nasti.aw_ready = 1'b0; nasti.w_ready = 1'b0; nasti.b_valid = 1'b0;
        nasti.ar_ready = 1'b0; nasti.r_valid = 1'b0; nasti.r_last  = 1'b0;
        nasti.b_resp   = 2'b00; nasti.r_resp = 2'b00; nasti.r_data = '0;
        nasti.b_id = '0; nasti.b_user = '0; nasti.r_id = '0; nasti.r_user = '0;
        wd_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int    beats    = 0;
        int    addr_cyc = 0;
        int    phase    = 0;
        int    cyc      = 0;
        bit    tog      = 1'b0;
        bit    early    = 1'b0;
        bit    early_w  = 1'b0;
        bit    rnd;
        int    last_at;
        string t;
        t = $sformatf("v%0d", idx);
        last_at = (v.last_beat < 0) ? int'(v.len) : v.last_beat;

        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
        #1 chk({t, "_req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        while (phase < 3 && cyc < BUDGET) begin
            rnd = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            nasti.aw_ready = v.wr  && phase == 0 && addr_cyc >= v.addr_delay;
            nasti.ar_ready = !v.wr && phase == 0 && addr_cyc >= v.addr_delay;
            wd_valid       = v.wr && rnd;
            wd_data        = pat(v.addr, beats);
            wd_strb        = '1;
            nasti.w_ready  = v.wr && phase == 1 && (!v.stall || tog);
            nasti.b_valid  = v.wr && phase == 2;
            nasti.b_resp   = v.bresp_err ? 2'b10 : 2'b00;
            nasti.r_valid  = !v.wr && phase == 1 && rnd;
            nasti.r_data   = pat(v.addr, beats);
            nasti.r_resp   = (beats == v.err_beat) ? 2'b11 : 2'b00;
            nasti.r_last   = (beats == last_at);
            rd_ready       = !v.stall || tog;
            #1;
            if (cyc == 0) chk({t, "_addr_valid_next_cycle"}, v.wr ? nasti.aw_valid : nasti.ar_valid, 1);
            if (done) early = 1'b1;
            if (phase == 0) begin
                if (nasti.w_valid || wd_ready) early_w = 1'b1;
                if (v.wr ? (nasti.aw_valid && nasti.aw_ready) : (nasti.ar_valid && nasti.ar_ready)) begin
                    chk({t, "_addr"},  v.wr ? nasti.aw_addr  : nasti.ar_addr,  v.addr);
                    chk({t, "_len"},   v.wr ? nasti.aw_len   : nasti.ar_len,   v.len);
                    chk({t, "_size"},  v.wr ? nasti.aw_size  : nasti.ar_size,  4);
                    chk({t, "_burst"}, v.wr ? nasti.aw_burst : nasti.ar_burst, 1);
                    chk({t, "_id"},    v.wr ? nasti.aw_id    : nasti.ar_id,    0);
                    phase = 1;
                end else begin
                    addr_cyc++;
                end
            end else if (phase == 1 && v.wr) begin
                chk({t, "_w_valid_mirror"}, nasti.w_valid, wd_valid);
                chk({t, "_wd_ready_mirror"}, wd_ready, nasti.w_ready);
                if (nasti.w_valid && nasti.w_ready) begin
                    chk($sformatf("%s_w_data_b%0d", t, beats), nasti.w_data, pat(v.addr, beats));
                    chk($sformatf("%s_w_strb_b%0d", t, beats), nasti.w_strb, {SW{1'b1}});
                    chk($sformatf("%s_w_last_b%0d", t, beats), nasti.w_last, beats == int'(v.len));
                    beats++;
                    if (beats == v.exp_beats) phase = 2;
                end
            end else if (phase == 1) begin
                chk({t, "_r_ready_mirror"}, nasti.r_ready, rd_ready);
                chk({t, "_rd_valid_mirror"}, rd_valid, nasti.r_valid);
                if (nasti.r_valid && nasti.r_ready) begin
                    chk($sformatf("%s_rd_data_b%0d", t, beats), rd_data, pat(v.addr, beats));
                    chk($sformatf("%s_rd_last_b%0d", t, beats), rd_last, beats == int'(v.len));
                    beats++;
                    if (beats == v.exp_beats) phase = 3;
                end
            end else if (phase == 2) begin
                if (nasti.b_ready) phase = 3;
            end
            tog = !tog;
            cyc++;
            @(negedge clk);
        end
        slave_idle();
        #1;
        chk({t, "_in_budget"}, cyc < BUDGET, 1);
        chk({t, "_beats"}, beats, v.exp_beats);
        chk({t, "_no_early_done"}, early, 0);
        chk({t, "_no_early_w"}, early_w, 0);
        chk({t, "_done"}, done, 1);
        chk({t, "_err"}, err, v.exp_err);
        chk({t, "_req_ready_during_done"}, req_ready, 0);
        @(negedge clk);
        #1;
        chk({t, "_done_one_cycle"}, done, 0);
        chk({t, "_req_ready_after_done"}, req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_done;
        vec_t big;
        //           wr  addr      len   dly berr ebeat lbeat stall beats err
        vecs[0] = '{1, 16'h0100, 8'd3, 2, 0, -1, -1,  0, 4, 0};
        vecs[1] = '{0, 16'h0040, 8'd0, 0, 0, -1, -1,  0, 1, 0};
        vecs[2] = '{0, 16'h0200, 8'd7, 1, 0, -1, -1,  1, 8, 0};
        vecs[3] = '{1, 16'h0300, 8'd1, 0, 1, -1, -1,  0, 2, 1};
        vecs[4] = '{0, 16'h0400, 8'd3, 0, 0,  2, -1,  0, 4, 1};
        vecs[5] = '{0, 16'h0500, 8'd3, 0, 0, -1,  1,  0, 2, 1};
        vecs[6] = '{0, 16'h0600, 8'd2, 0, 0, -1, 300, 0, 3, 1};
        vecs[7] = '{1, 16'h0700, 8'd0, 3, 0, -1, -1,  1, 1, 0};
        vecs[8] = '{1, 16'h0800, 8'd5, 0, 0, -1, -1,  1, 6, 0};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wd_data = '0; wd_strb = '0;
        slave_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_aw_valid", nasti.aw_valid, 0);
        chk("rst_ar_valid", nasti.ar_valid, 0);
        chk("rst_w_valid", nasti.w_valid, 0);
        chk("rst_b_ready", nasti.b_ready, 0);
        chk("rst_r_ready", nasti.r_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i], i);

        // Reset in the middle of a write burst, after its first data beat.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0900; req_len = 8'd3;
        @(negedge clk);
        req_valid = 1'b0; nasti.aw_ready = 1'b1;
        wd_valid = 1'b1; wd_data = pat(16'h0900, 0); wd_strb = '1; nasti.w_ready = 1'b1;
        #1 chk("mid_rst_aw_valid", nasti.aw_valid, 1);
        @(negedge clk);
        nasti.aw_ready = 1'b0;
        #1 chk("mid_rst_first_beat", nasti.w_valid && wd_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_still_in_w", nasti.w_valid, 1);
        @(negedge clk);
        #1;
        chk("mid_rst_aw_valid_low", nasti.aw_valid, 0);
        chk("mid_rst_ar_valid_low", nasti.ar_valid, 0);
        chk("mid_rst_w_valid_low", nasti.w_valid, 0);
        chk("mid_rst_wd_ready_low", wd_ready, 0);
        chk("mid_rst_b_ready_low", nasti.b_ready, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        slave_idle();
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 if (done) seen_done = 1'b1;
        end
        chk("mid_rst_no_done_after", seen_done, 0);

        // Maximum-length read right after the reset.
        big = '{0, 16'h1000, 8'd255, 0, 0, -1, -1, 0, 256, 0};
        run_txn(big, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
